// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C receive framer.
package i2c_pkg;

   localparam int unsigned BYTE_W             = 8;
   localparam int unsigned CNT_W              = 4;
   localparam int unsigned ACK_BIT_CNT        = 8;
   localparam int unsigned ADDR_W             = 7;
   localparam logic [ADDR_W-1:0] DEFAULT_SLAVE_ADDR = 7'h5A;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_DATA,
      ST_DATA_ACK,
      ST_HOLD,
      ST_WAIT_STOP
   } state_t;

   // True when the upper seven bits of a received address byte equal addr.
   function automatic logic addr_hit(input logic [BYTE_W-1:0] shift,
                                     input logic [ADDR_W-1:0] addr);
      return shift[BYTE_W-1:1] == addr;
   endfunction

endpackage

// File: rtl/i2c_bus_cond.sv
// START/STOP condition detector: tracks SCL level and SDA history.
module i2c_bus_cond
   import i2c_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic i_rise,
   input  logic i_fall,
   input  logic i_sda,
   output logic o_start_c,
   output logic o_stop_c,
   output logic o_start_found,
   output logic o_stop_found
);

   logic r_scl_level;
   logic r_sda_prev;

   // SCL level follows legal edge pulses; simultaneous edges leave it alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_scl_level <= 1'b1;
         r_sda_prev  <= 1'b1;
      end else begin
         r_sda_prev <= i_sda;
         if (i_rise && !i_fall) begin
            r_scl_level <= 1'b1;
         end else if (i_fall && !i_rise) begin
            r_scl_level <= 1'b0;
         end
      end
   end

   // SDA transition while SCL high; a coincident SCL fall masks it.
   assign o_start_c = r_scl_level &  r_sda_prev & ~i_sda & ~i_fall;
   assign o_stop_c  = r_scl_level & ~r_sda_prev &  i_sda & ~i_fall;

   // One-cycle pulses, one clock after the detecting cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_start_found <= 1'b0;
         o_stop_found  <= 1'b0;
      end else begin
         o_start_found <= o_start_c;
         o_stop_found  <= o_stop_c;
      end
   end

endmodule

// File: rtl/i2c_rx_framer.sv
// I2C slave receive framer: address match, ACK request, data byte capture.
module i2c_rx_framer
   import i2c_pkg::*;
#(
   parameter logic [ADDR_W-1:0] SLAVE_ADDR = DEFAULT_SLAVE_ADDR
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              rising_edge_found,
   input  logic              falling_edge_found,
   input  logic              sda_in,
   output logic [BYTE_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              addr_match,
   output logic              rw_mode,
   output logic              ack_drive,
   output logic              start_found,
   output logic              stop_found,
   output logic              busy
);

   state_t            r_state;
   logic [CNT_W-1:0]  r_bit_cnt;
   logic [BYTE_W-1:0] r_shift;

   logic              w_start;
   logic              w_stop;
   logic              w_rise;
   logic              w_fall;
   logic              w_cnt_full;
   logic              w_last_bit;
   logic [BYTE_W-1:0] w_shift_nxt;

   i2c_bus_cond u_bus_cond (
      .clk           (clk),
      .rst           (rst),
      .i_rise        (rising_edge_found),
      .i_fall        (falling_edge_found),
      .i_sda         (sda_in),
      .o_start_c     (w_start),
      .o_stop_c      (w_stop),
      .o_start_found (start_found),
      .o_stop_found  (stop_found)
   );

   // Qualified edges: both at once is illegal and treated as no edge.
   assign w_rise      = rising_edge_found & ~falling_edge_found;
   assign w_fall      = falling_edge_found & ~rising_edge_found;
   assign w_cnt_full  = (r_bit_cnt == CNT_W'(ACK_BIT_CNT));
   assign w_last_bit  = (r_bit_cnt == CNT_W'(ACK_BIT_CNT - 1));
   assign w_shift_nxt = {r_shift[BYTE_W-2:0], sda_in};

   // Frame FSM with bit counter, shift register and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         addr_match <= 1'b0;
         rw_mode    <= 1'b0;
         ack_drive  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if (w_start) begin
            r_state    <= ST_ADDR;
            r_bit_cnt  <= '0;
            ack_drive  <= 1'b0;
            addr_match <= 1'b0;
            busy       <= 1'b1;
         end else if (w_stop) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            ack_drive  <= 1'b0;
            addr_match <= 1'b0;
            busy       <= 1'b0;
         end else begin
            case (r_state)
               ST_ADDR, ST_DATA: begin
                  if (w_rise && !w_cnt_full) begin
                     r_shift   <= w_shift_nxt;
                     r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                     if (r_state == ST_DATA && w_last_bit) begin
                        rx_data  <= w_shift_nxt;
                        rx_valid <= 1'b1;
                     end
                  end else if (w_fall && w_cnt_full) begin
                     if (r_state == ST_DATA) begin
                        ack_drive <= 1'b1;
                        r_state   <= ST_DATA_ACK;
                     end else if (addr_hit(r_shift, SLAVE_ADDR)) begin
                        ack_drive  <= 1'b1;
                        addr_match <= 1'b1;
                        rw_mode    <= r_shift[0];
                        r_state    <= ST_ADDR_ACK;
                     end else begin
                        r_state <= ST_WAIT_STOP;
                     end
                  end
               end
               ST_ADDR_ACK: begin
                  if (w_fall) begin
                     ack_drive <= 1'b0;
                     r_bit_cnt <= '0;
                     r_state   <= rw_mode ? ST_HOLD : ST_DATA;
                  end
               end
               ST_DATA_ACK: begin
                  if (w_fall) begin
                     ack_drive <= 1'b0;
                     r_bit_cnt <= '0;
                     r_state   <= ST_DATA;
                  end
               end
               ST_IDLE, ST_HOLD, ST_WAIT_STOP: begin
               end
               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_rx_framer.sv
// Scoreboard bench for i2c_rx_framer with a frame-level reference model.
module tb_i2c_rx_framer;

   localparam logic [6:0] SA = 7'h5A;

   logic       clk = 1'b0;
   logic       rst;
   logic       rising_edge_found;
   logic       falling_edge_found;
   logic       sda_in;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       addr_match;
   logic       rw_mode;
   logic       ack_drive;
   logic       start_found;
   logic       stop_found;
   logic       busy;

   always #5 clk = ~clk;

   i2c_rx_framer #(.SLAVE_ADDR(SA)) dut (
      .clk                (clk),
      .rst                (rst),
      .rising_edge_found  (rising_edge_found),
      .falling_edge_found (falling_edge_found),
      .sda_in             (sda_in),
      .rx_data            (rx_data),
      .rx_valid           (rx_valid),
      .addr_match         (addr_match),
      .rw_mode            (rw_mode),
      .ack_drive          (ack_drive),
      .start_found        (start_found),
      .stop_found         (stop_found),
      .busy               (busy)
   );

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_b;
   int         obs_starts = 0;
   int         obs_stops  = 0;
   int         exp_starts = 0;
   int         exp_stops  = 0;
   logic       prev_start = 1'b0;
   logic       prev_stop  = 1'b0;

   // Reference model: bench SCL level and frame phase
   // phase 0: no frame, 1: address expected, 2: write data accepted, 3: ignored bytes
   logic       scl;
   int         m_phase;
   logic       m_match;
   logic       m_rw;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops expected bytes on rx_valid, counts condition pulses.
   always @(negedge clk) begin
      if (!rst) begin
         if (rx_valid) begin
            if (exp_q.size() == 0) begin
               check("rx_valid_spurious", 1, 0);
            end else begin
               exp_b = exp_q.pop_front();
               check("rx_data", int'(rx_data), int'(exp_b));
            end
         end
         if (start_found) begin
            obs_starts++;
            check("start_width", int'(prev_start), 0);
         end
         if (stop_found) begin
            obs_stops++;
            check("stop_width", int'(prev_stop), 0);
         end
      end
      prev_start = start_found;
      prev_stop  = stop_found;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_rise();
      rising_edge_found = 1'b1;
      idle(1);
      rising_edge_found = 1'b0;
      scl = 1'b1;
   endtask

   task automatic pulse_fall();
      falling_edge_found = 1'b1;
      idle(1);
      falling_edge_found = 1'b0;
      scl = 1'b0;
   endtask

   task automatic pulse_both();
      rising_edge_found  = 1'b1;
      falling_edge_found = 1'b1;
      idle(1);
      rising_edge_found  = 1'b0;
      falling_edge_found = 1'b0;
      idle(1);
   endtask

   task automatic set_sda(input logic v);
      sda_in = v;
      idle(2);
   endtask

   task automatic send_bit(input logic b);
      set_sda(b);
      pulse_rise();
      idle(2);
      pulse_fall();
      idle(1);
   endtask

   task automatic do_start();
      if (!scl) begin
         set_sda(1'b1);
         pulse_rise();
         idle(2);
      end
      sda_in = 1'b0;
      exp_starts++;
      m_phase = 1;
      m_match = 1'b0;
      idle(3);
      check("start_busy", int'(busy), 1);
      check("start_addr_match", int'(addr_match), 0);
      pulse_fall();
      idle(1);
   endtask

   task automatic do_stop();
      set_sda(1'b0);
      pulse_rise();
      idle(2);
      sda_in = 1'b1;
      exp_stops++;
      m_phase = 0;
      m_match = 1'b0;
      idle(3);
      check("stop_busy", int'(busy), 0);
      check("stop_addr_match", int'(addr_match), 0);
      check("stop_ack", int'(ack_drive), 0);
      check("start_count", obs_starts, exp_starts);
      check("stop_count", obs_stops, exp_stops);
   endtask

   // Eight bits MSB first plus the ninth (ACK) clock; both_at injects an illegal edge pair.
   task automatic send_byte(input logic [7:0] b, input int both_at);
      logic exp_ack;
      exp_ack = 1'b0;
      if (m_phase == 2) exp_q.push_back(b);
      for (int i = 7; i >= 0; i--) begin
         if (i == both_at) pulse_both();
         send_bit(b[i]);
      end
      case (m_phase)
         1: begin
            m_match = (b[7:1] == SA);
            exp_ack = m_match;
            if (m_match) begin
               m_rw    = b[0];
               m_phase = b[0] ? 3 : 2;
            end else begin
               m_phase = 3;
            end
         end
         2: exp_ack = 1'b1;
         default: exp_ack = 1'b0;
      endcase
      set_sda(1'b1);
      check("ack_slot", int'(ack_drive), int'(exp_ack));
      pulse_rise();
      idle(2);
      check("ack_9th_high", int'(ack_drive), int'(exp_ack));
      check("addr_match", int'(addr_match), int'(m_match));
      check("rw_mode", int'(rw_mode), int'(m_rw));
      pulse_fall();
      idle(1);
      check("ack_release", int'(ack_drive), 0);
   endtask

   task automatic check_reset_vals();
      check("rst_rx_data", int'(rx_data), 0);
      check("rst_rx_valid", int'(rx_valid), 0);
      check("rst_addr_match", int'(addr_match), 0);
      check("rst_rw_mode", int'(rw_mode), 0);
      check("rst_ack_drive", int'(ack_drive), 0);
      check("rst_start_found", int'(start_found), 0);
      check("rst_stop_found", int'(stop_found), 0);
      check("rst_busy", int'(busy), 0);
   endtask

   // SDA changes in the same cycle as an SCL fall must not count as START/STOP.
   task automatic glitch_test();
      falling_edge_found = 1'b1;
      sda_in = 1'b0;
      idle(1);
      falling_edge_found = 1'b0;
      scl = 1'b0;
      idle(3);
      pulse_rise();
      idle(3);
      falling_edge_found = 1'b1;
      sda_in = 1'b1;
      idle(1);
      falling_edge_found = 1'b0;
      scl = 1'b0;
      idle(3);
      pulse_rise();
      idle(3);
      check("glitch_start_count", obs_starts, exp_starts);
      check("glitch_stop_count", obs_stops, exp_stops);
      check("glitch_busy", int'(busy), 0);
   endtask

   initial begin
      logic [7:0] a;
      int         nb;

      rst = 1'b1;
      rising_edge_found = 1'b0;
      falling_edge_found = 1'b0;
      sda_in = 1'b1;
      scl = 1'b1;
      m_phase = 0;
      m_match = 1'b0;
      m_rw = 1'b0;
      idle(3);
      check_reset_vals();
      rst = 1'b0;
      idle(3);

      // Matched write of one byte
      do_start();
      send_byte({SA, 1'b0}, -1);
      send_byte(8'hC3, -1);
      do_stop();
      check("rx_data_c3", int'(rx_data), 'hC3);

      glitch_test();

      // Unmatched address: no ACK, no data
      do_start();
      send_byte({7'h21, 1'b0}, -1);
      send_byte(8'hA5, -1);
      check("nack_busy", int'(busy), 1);
      do_stop();

      // Matched read: SCL activity in HOLD yields nothing
      do_start();
      send_byte({SA, 1'b1}, -1);
      send_byte(8'hFF, -1);
      send_byte(8'h00, -1);
      check("read_busy", int'(busy), 1);
      do_stop();

      // Partial byte dropped by repeated START
      do_start();
      send_byte({SA, 1'b0}, -1);
      for (int i = 0; i < 4; i++) send_bit(i[0]);
      do_start();
      send_byte({SA, 1'b0}, -1);
      send_byte(8'h7E, -1);
      do_stop();
      check("rx_data_7e", int'(rx_data), 'h7E);

      // Illegal simultaneous edges ignored mid-byte
      do_start();
      send_byte({SA, 1'b0}, -1);
      send_byte(8'h96, 3);
      do_stop();

      // Reset mid-byte, then a clean frame
      do_start();
      send_byte({SA, 1'b0}, -1);
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      rst = 1'b1;
      idle(1);
      check_reset_vals();
      sda_in = 1'b1;
      m_phase = 0;
      m_match = 1'b0;
      m_rw = 1'b0;
      idle(2);
      rst = 1'b0;
      idle(2);
      do_start();
      send_byte({SA, 1'b0}, -1);
      send_byte(8'h11, -1);
      do_stop();
      check("rx_data_11", int'(rx_data), 'h11);

      // Random frames
      for (int f = 0; f < 30; f++) begin
         if ($urandom_range(0, 1) == 1) a = {SA, 1'($urandom_range(0, 1))};
         else a = 8'($urandom);
         nb = $urandom_range(0, 3);
         do_start();
         send_byte(a, -1);
         for (int k = 0; k < nb; k++) send_byte(8'($urandom), -1);
         if ($urandom_range(0, 3) == 0) begin
            do_start();
            send_byte({SA, 1'b0}, -1);
            send_byte(8'($urandom), -1);
         end
         do_stop();
      end

      idle(5);
      check("queue_drained", exp_q.size(), 0);
      check("final_start_count", obs_starts, exp_starts);
      check("final_stop_count", obs_stops, exp_stops);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/i2c_rx_framer.md
I2C_RX_FRAMER -- requirements
Module: i2c_rx_framer

Interface
REQ-001 Parameter SLAVE_ADDR, default 7'h5A, 7-bit address this slave acknowledges.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 rising_edge_found  input  1  one-cycle pulse: SCL rose (from upstream SCL edge detector).
REQ-005 falling_edge_found  input  1  one-cycle pulse: SCL fell.
REQ-006 sda_in  input  1  synchronized SDA level.
REQ-007 rx_data  output  8  last received data byte, MSB first on bus.
REQ-008 rx_valid  output  1  one-cycle pulse: rx_data updated.
REQ-009 addr_match  output  1  high from address ACK until next START/STOP when address matched.
REQ-010 rw_mode  output  1  R/W bit of last matched address byte (1 = read).
REQ-011 ack_drive  output  1  request to pull SDA low (ACK slot).
REQ-012 start_found  output  1  one-cycle pulse: START or repeated START detected.
REQ-013 stop_found  output  1  one-cycle pulse: STOP detected.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 Block SHALL keep scl_level register: set on rising_edge_found, cleared on falling_edge_found; and sda_prev register = sda_in delayed one cycle.
REQ-016 START SHALL be detected when scl_level=1, sda_prev=1, sda_in=0, falling_edge_found=0; STOP when scl_level=1, sda_prev=0, sda_in=1, falling_edge_found=0.
REQ-017 start_found/stop_found SHALL pulse in the cycle after the detecting cycle, exactly one cycle.
REQ-018 States: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, HOLD, WAIT_STOP.
REQ-019 START in any state SHALL force ADDR, bit_cnt=0, ack_drive=0, addr_match=0; takes priority over all other transitions that cycle.
REQ-020 STOP in any state SHALL force IDLE, ack_drive=0, addr_match=0.
REQ-021 In ADDR/DATA, each rising_edge_found SHALL shift sda_in into 8-bit shift register LSB end and increment 4-bit bit_cnt; no shifting once bit_cnt=8.
REQ-022 ADDR, bit_cnt=8, falling_edge_found: if shift[7:1]==SLAVE_ADDR then ack_drive=1, addr_match=1, rw_mode=shift[0], go ADDR_ACK; else go WAIT_STOP, ack_drive stays 0.
REQ-023 ADDR_ACK, falling_edge_found: ack_drive=0, bit_cnt=0; go DATA if rw_mode=0, HOLD if rw_mode=1.
REQ-024 DATA, cycle bit_cnt becomes 8: rx_data loaded from shift register, rx_valid pulses next cycle (latency 1 clk after 8th rising_edge_found).
REQ-025 DATA, bit_cnt=8, falling_edge_found: ack_drive=1, go DATA_ACK; DATA_ACK, falling_edge_found: ack_drive=0, bit_cnt=0, go DATA.
REQ-026 HOLD and WAIT_STOP SHALL ignore SCL edges; exit only on START/STOP.
REQ-027 IDLE SHALL ignore SCL edges.
REQ-028 Simultaneous rising_edge_found and falling_edge_found (illegal) SHALL be ignored; state unchanged.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 rst=1 SHALL immediately force IDLE, scl_level=1, sda_prev=1, bit_cnt=0, shift=0, rx_data=8'h00, rx_valid=0, addr_match=0, rw_mode=0, ack_drive=0, start_found=0, stop_found=0, busy=0.
REQ-031 Reset mid-byte SHALL discard partial data; no rx_valid after release until a full new frame.

Structure
REQ-032 State enum, ACK bit count constant (8) and default address SHALL live in shared package i2c_pkg.
REQ-033 START/STOP detection (scl_level, sda_prev, pulses) SHALL be sub-module i2c_bus_cond; FSM, counter and shift register in top.

Verification
REQ-034 START, addr 0x5A + W, data 0xC3, STOP -> start_found 1 pulse, ack_drive during both 9th clocks, rx_data=0xC3 with one rx_valid, stop_found 1 pulse, busy low after.
REQ-035 START, addr 0x21 + W, 8 data bits -> ack_drive never asserted, no rx_valid, WAIT_STOP until STOP.
REQ-036 START, 0x5A + R -> addr_match=1, rw_mode=1, ACK issued, HOLD; following SCL edges give no rx_valid.
REQ-037 0x5A + W, 4 data bits, repeated START, 0x5A + W, 0x7E -> partial byte dropped, rx_data=0x7E, one rx_valid.
REQ-038 rst pulse after 5th data bit, then full frame 0x5A + W, 0x11 -> all outputs at reset values during rst, then rx_data=0x11.
REQ-039 SDA toggles in same cycle as falling_edge_found while SCL high -> no start_found/stop_found.
